// File: rtl/fifo_rd_stream_if.sv
// Handshake bundle between the FIFO read port, fifo_rd_stream and the stream consumer.
// master = fifo_rd_stream side, slave = FIFO/consumer side.
interface fifo_rd_stream_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BUF_DEPTH = 2
);
    localparam int unsigned LVL_W = $clog2(BUF_DEPTH) + 1;

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic [LVL_W-1:0]  buf_level;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data, buf_level
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, buf_level
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a registered-output synchronous FIFO into a valid/ready stream via a small skid buffer.
// Optional FIFO_RD_STREAM_STATS_EN adds word_cnt / stall_cnt statistics outputs.
module fifo_rd_stream #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    fifo_rd_stream_if.master   bus
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]        word_cnt,
    output logic [31:0]        stall_cnt
`endif
);
    localparam int unsigned IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SUM_W = LVL_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_DEPTH - 1);

    logic [DATA_W-1:0] buf_mem [BUF_DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [LVL_W-1:0]  cnt;
    logic              rd_q;
    logic              valid;
    logic              pop;
    logic [SUM_W-1:0]  commit;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    // Occupancy after this cycle, counting the word already in flight from the FIFO.
    assign valid  = (cnt != '0);
    assign pop    = valid && bus.m_ready;
    assign commit = SUM_W'(cnt) + SUM_W'(rd_q) - SUM_W'(pop);

    assign bus.fifo_rd_en = !rst && !bus.fifo_empty && (commit < SUM_W'(BUF_DEPTH));
    assign bus.m_valid    = valid;
    assign bus.m_data     = buf_mem[rd_idx];
    assign bus.buf_level  = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            rd_q    <= 1'b0;
            buf_mem <= '{default: '0};
        end else begin
            rd_q <= bus.fifo_rd_en;
            if (rd_q) begin
                buf_mem[wr_idx] <= bus.fifo_data;
                wr_idx          <= next_idx(wr_idx);
            end
            if (pop) begin
                rd_idx <= next_idx(rd_idx);
            end
            cnt <= LVL_W'(commit);
        end
    end

    // Read issue logic must never let a capture land in a full buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rd_q && (cnt == LVL_W'(BUF_DEPTH))))
                else $error("fifo_rd_stream: capture into full skid buffer");
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    // Popped words wrap; stall cycles saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop) begin
                word_cnt <= word_cnt + 32'd1;
            end
            if (valid && !bus.m_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO + in-order scoreboard, directed and random phases.
// Stats checks are active when FIFO_RD_STREAM_STATS_EN is defined.
module tb_fifo_rd_stream;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned LVL_W     = $clog2(BUF_DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) bus ();

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0] word_cnt;
    logic [31:0] stall_cnt;
`endif

    fifo_rd_stream #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // Behavioural FIFO with registered read data.
    logic [DATA_W-1:0] mem [1024];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_data <= mem[rd_ptr[9:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    logic [DATA_W-1:0] pend_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int pops    = 0;

    logic              s_v, s_re, s_emp, s_pop;
    logic [DATA_W-1:0] s_d;
    logic [LVL_W-1:0]  s_lvl;
    int                s_cyc;
    logic              prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_d;

    int first_re, first_v, first_pop, last_pop, n_re, pops0, pushed, n_disc, guard;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v)
            else begin
                errors++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
            end
    endtask

    // One clock: load pending FIFO writes, drive inputs, sample mid-cycle, score the pop.
    task automatic tick(input logic rdy, input logic r);
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] exp_w;
        @(negedge clk);
        while (pend_q.size() > 0) begin
            w = pend_q.pop_front();
            mem[wr_ptr[9:0]] = w;
            exp_q.push_back(w);
            wr_ptr++;
        end
        bus.m_ready = rdy;
        rst         = r;
        #2;
        s_v   = bus.m_valid;
        s_d   = bus.m_data;
        s_re  = bus.fifo_rd_en;
        s_emp = bus.fifo_empty;
        s_lvl = bus.buf_level;
        s_pop = 1'b0;
        s_cyc = cyc;
        chk("level_bound", 64'(s_lvl <= LVL_W'(BUF_DEPTH)), 64'd1);
        chk("rd_en_when_empty", 64'(s_re && s_emp), 64'd0);
        if (r) chk("rd_en_in_rst", 64'(s_re), 64'd0);
        if (prev_hold) begin
            chk("hold_valid", 64'(s_v), 64'd1);
            chk("hold_data", 64'(s_d), 64'(prev_d));
        end
        if (s_v && rdy && !r) begin
            if (exp_q.size() == 0) exp_w = 'x;
            else exp_w = exp_q.pop_front();
            chk("pop_data", 64'(s_d), 64'(exp_w));
            pops++;
            s_pop = 1'b1;
        end
        prev_hold = s_v && !rdy && !r;
        prev_d    = s_d;
        cyc++;
    endtask

    initial begin
        bus.m_ready = 1'b0;
        rst         = 1'b1;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);

        // Idle after reset with an empty FIFO.
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            chk("idle_rd_en", 64'(s_re), 64'd0);
            chk("idle_valid", 64'(s_v), 64'd0);
            chk("idle_data", 64'(s_d), 64'd0);
            chk("idle_level", 64'(s_lvl), 64'd0);
        end

        // Preloaded burst, consumer always ready.
        for (int i = 1; i <= 8; i++) pend_q.push_back(DATA_W'(i));
        first_re = -1; first_v = -1; first_pop = -1; last_pop = -1; n_re = 0; pops0 = pops;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            if (s_re) begin
                n_re++;
                if (first_re < 0) first_re = s_cyc;
            end
            if (s_v && first_v < 0) first_v = s_cyc;
            if (s_pop) begin
                if (first_pop < 0) first_pop = s_cyc;
                last_pop = s_cyc;
            end
        end
        chk("burst_latency", 64'(first_v - first_re), 64'd2);
        chk("burst_pops", 64'(pops - pops0), 64'd8);
        chk("burst_span", 64'(last_pop - first_pop), 64'd7);
        chk("burst_rd_en_cnt", 64'(n_re), 64'd8);
        chk("burst_idle_rd_en", 64'(s_re), 64'd0);

        // Back-pressure: only BUF_DEPTH words may leave the FIFO.
        for (int i = 1; i <= 8; i++) pend_q.push_back(DATA_W'(i));
        n_re = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            if (s_re) n_re++;
            if (s_v) chk("bp_data_held", 64'(s_d), 64'd1);
        end
        chk("bp_rd_en_pulses", 64'(n_re), 64'(BUF_DEPTH));
        chk("bp_level", 64'(s_lvl), 64'(BUF_DEPTH));
        pops0 = pops;
        guard = 0;
        while (exp_q.size() > 0 && guard < 40) begin
            tick(1'b1, 1'b0);
            guard++;
        end
        chk("bp_release_pops", 64'(pops - pops0), 64'd8);

        // Random back-pressure over 100 incrementing words.
        pops0 = pops; pushed = 0; guard = 0;
        while ((pushed < 100 || exp_q.size() > 0) && guard < 2000) begin
            if (pushed < 100 && $urandom_range(1, 0) == 1) begin
                pend_q.push_back(32'h1000_0000 + DATA_W'(pushed));
                pushed++;
            end
            tick(1'($urandom_range(1, 0)), 1'b0);
            guard++;
        end
        chk("rand_pushed", 64'(pushed), 64'd100);
        chk("rand_pop_count", 64'(pops - pops0), 64'd100);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        chk("rand_quiet_level", 64'(s_lvl), 64'd0);

        // Reset with one word buffered and one in flight.
        for (int i = 0; i < 4; i++) pend_q.push_back(32'hA0 + DATA_W'(i));
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("pre_rst_level", 64'(s_lvl), 64'd1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("post_rst_valid", 64'(s_v), 64'd0);
        chk("post_rst_level", 64'(s_lvl), 64'd0);
        n_disc = rd_ptr - pops;
        chk("rst_discard", 64'(n_disc), 64'd2);
        for (int i = 0; i < n_disc && exp_q.size() > 0; i++) void'(exp_q.pop_front());
        pops0 = pops; guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick(1'b1, 1'b0);
            guard++;
        end
        chk("rst_resume_pops", 64'(pops - pops0), 64'd2);

`ifdef FIFO_RD_STREAM_STATS_EN
        // Statistics: 8 pops with 5 stall cycles, then cleared by reset.
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("stats_rst_words", 64'(word_cnt), 64'd0);
        chk("stats_rst_stalls", 64'(stall_cnt), 64'd0);
        for (int i = 0; i < 8; i++) pend_q.push_back(32'hB0 + DATA_W'(i));
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0);
        guard = 0;
        while (exp_q.size() > 0 && guard < 30) begin
            tick(1'b1, 1'b0);
            guard++;
        end
        tick(1'b1, 1'b0);
        chk("stats_words", 64'(word_cnt), 64'd8);
        chk("stats_stalls", 64'(stall_cnt), 64'd5);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("stats_clr_words", 64'(word_cnt), 64'd0);
        chk("stats_clr_stalls", 64'(stall_cnt), 64'd0);
`endif

        chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
